// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// State encodings follow the control_state output coding.
package interrupt_ack_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'b000,
      ACK1 = 3'b001,
      ACK2 = 3'b010,
      ACK3 = 3'b011
   } ack_state_t;

   localparam logic [7:0] CALL_OPCODE = 8'hCD;

endpackage

// File: rtl/interrupt_ack_sequencer_onehot_to_num.sv
// One-hot to binary encoder for the latched IR.
// The lowest set bit wins if more than one bit is set.
module onehot_to_num (
   input  logic [7:0] onehot,
   output logic [2:0] num
);

   always_comb begin
      num = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (onehot[i]) num = 3'(i);
      end
   end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INTA pulse sequencer: latches the IR and sequences the vector bytes.
// Define ACK_SEQ_8080_MODE_EN to enable the 3-pulse 8080 sequence.
module interrupt_ack_sequencer
   import interrupt_ack_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inta_n,
   input  logic       mode_8086,
   input  logic       adi,
   input  logic [7:0] highest_request,
   input  logic [4:0] vector_base,
   input  logic [2:0] addr_low,
   input  logic [7:0] addr_high,
   input  logic       cascade_slave,
   input  logic       cascade_output_ack_2_3,
   output logic [2:0] control_state,
   output logic [7:0] acknowledge_interrupt,
   output logic [7:0] data_out,
   output logic       data_out_en,
   output logic       end_of_ack,
   output logic       spurious_ack
);

   ack_state_t state_q, state_d;
   logic       inta_q;
   logic       mode_q, mode_d;
   logic       spur_q, spur_d;
   logic       eoa_q, eoa_d;
   logic [7:0] ack_q, ack_d;
   logic       fall, rise;
   logic       mode_in;
   logic [2:0] n;
   logic [7:0] call_byte, hi_byte;
   logic       drive;
   logic [7:0] byte_sel;

   assign fall = inta_q & ~inta_n;
   assign rise = ~inta_q & inta_n;

   onehot_to_num u_enc (
      .onehot (ack_q),
      .num    (n)
   );

`ifdef ACK_SEQ_8080_MODE_EN
   assign mode_in   = mode_8086;
   assign call_byte = adi ? {addr_low[2:1], n, 3'b000}
                          : {addr_low, n, 2'b00};
   assign hi_byte   = addr_high;
`else
   logic unused_cfg;
   assign unused_cfg = ^{mode_8086, adi, addr_low, addr_high};
   assign mode_in    = 1'b1;
   assign call_byte  = 8'h00;
   assign hi_byte    = 8'h00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         inta_q  <= 1'b0;
         mode_q  <= 1'b1;
         spur_q  <= 1'b0;
         eoa_q   <= 1'b0;
         ack_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         inta_q  <= inta_n;
         mode_q  <= mode_d;
         spur_q  <= spur_d;
         eoa_q   <= eoa_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      spur_d  = spur_q;
      ack_d   = ack_q;
      eoa_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = ACK1;
               mode_d  = mode_in;
               // An empty request acknowledges IR7 as spurious
               if (highest_request == 8'h00) begin
                  ack_d  = 8'h80;
                  spur_d = 1'b1;
               end else begin
                  ack_d  = highest_request;
                  spur_d = 1'b0;
               end
            end
         end
         ACK1: begin
            if (fall) state_d = ACK2;
         end
         ACK2: begin
            if (fall && !mode_q) begin
               state_d = ACK3;
            end else if (rise && mode_q) begin
               state_d = IDLE;
               eoa_d   = 1'b1;
               ack_d   = 8'h00;
               spur_d  = 1'b0;
            end
         end
         ACK3: begin
            if (rise) begin
               state_d = IDLE;
               eoa_d   = 1'b1;
               ack_d   = 8'h00;
               spur_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      drive    = 1'b0;
      byte_sel = 8'h00;
      unique case (state_q)
         ACK1: begin
            drive    = ~mode_q & ~cascade_slave;
            byte_sel = CALL_OPCODE;
         end
         ACK2: begin
            drive    = cascade_output_ack_2_3;
            byte_sel = mode_q ? {vector_base, n} : call_byte;
         end
         ACK3: begin
            drive    = cascade_output_ack_2_3;
            byte_sel = hi_byte;
         end
         default: ;
      endcase
   end

   assign data_out_en           = drive & ~inta_n;
   assign data_out              = data_out_en ? byte_sel : 8'h00;
   assign control_state         = state_q;
   assign acknowledge_interrupt = ack_q;
   assign end_of_ack            = eoa_q;
   assign spurious_ack          = spur_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer.
// 8080 scenarios run only when ACK_SEQ_8080_MODE_EN is defined.
module tb_interrupt_ack_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inta_n = 1'b1;
   logic       mode_8086 = 1'b1;
   logic       adi = 1'b0;
   logic [7:0] highest_request = 8'h00;
   logic [4:0] vector_base = 5'h00;
   logic [2:0] addr_low = 3'b000;
   logic [7:0] addr_high = 8'h00;
   logic       cascade_slave = 1'b0;
   logic       cascade_output_ack_2_3 = 1'b1;
   logic [2:0] control_state;
   logic [7:0] acknowledge_interrupt;
   logic [7:0] data_out;
   logic       data_out_en;
   logic       end_of_ack;
   logic       spurious_ack;

   int n_vec = 0;
   int n_err = 0;
   logic saw_ack3 = 1'b0;

   interrupt_ack_sequencer dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .inta_n                 (inta_n),
      .mode_8086              (mode_8086),
      .adi                    (adi),
      .highest_request        (highest_request),
      .vector_base            (vector_base),
      .addr_low               (addr_low),
      .addr_high              (addr_high),
      .cascade_slave          (cascade_slave),
      .cascade_output_ack_2_3 (cascade_output_ack_2_3),
      .control_state          (control_state),
      .acknowledge_interrupt  (acknowledge_interrupt),
      .data_out               (data_out),
      .data_out_en            (data_out_en),
      .end_of_ack             (end_of_ack),
      .spurious_ack           (spurious_ack)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (control_state == 3'b011) saw_ack3 = 1'b1;
   end

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop();
      inta_n = 1'b0;
      tick();
   endtask

   task automatic lift();
      inta_n = 1'b1;
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_st"}, {5'd0, control_state}, 8'h00);
      chk({tag, "_ack"}, acknowledge_interrupt, 8'h00);
      chk({tag, "_dat"}, data_out, 8'h00);
      chk({tag, "_oth"},
          {5'd0, data_out_en, end_of_ack, spurious_ack}, 8'h00);
   endtask

   initial begin
      #1;
      chk_zero("rst");
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      // 8086 two-pulse sequence
      highest_request = 8'h08;
      vector_base     = 5'h11;
      drop();
      chk("p1_st", {5'd0, control_state}, 8'h01);
      chk("p1_ack", acknowledge_interrupt, 8'h08);
      chk("p1_en", {7'd0, data_out_en}, 8'h00);
      chk("p1_dat", data_out, 8'h00);
      highest_request = 8'h01;
      lift();
      chk("p1r_st", {5'd0, control_state}, 8'h01);
      drop();
      chk("p2_st", {5'd0, control_state}, 8'h02);
      chk("p2_en", {7'd0, data_out_en}, 8'h01);
      chk("p2_dat", data_out, 8'h8B);
      chk("p2_ack", acknowledge_interrupt, 8'h08);
      lift();
      chk("end_st", {5'd0, control_state}, 8'h00);
      chk("end_eoa", {7'd0, end_of_ack}, 8'h01);
      chk("end_ack", acknowledge_interrupt, 8'h00);
      tick();
      chk("eoa_1cyc", {7'd0, end_of_ack}, 8'h00);

      // spurious request
      highest_request = 8'h00;
      drop();
      chk("sp_ack", acknowledge_interrupt, 8'h80);
      chk("sp_flag", {7'd0, spurious_ack}, 8'h01);
      lift();
      drop();
      chk("sp_vec", data_out, 8'h8F);
      lift();
      chk("sp_clr", {7'd0, spurious_ack}, 8'h00);
      tick();

      // reset in ACK2 with inta_n low
      highest_request = 8'h02;
      drop();
      lift();
      drop();
      chk("r2_st", {5'd0, control_state}, 8'h02);
      chk("r2_dat", data_out, 8'h89);
      rst_n = 1'b0;
      #1;
      chk_zero("rmid");
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      chk("rrel_st", {5'd0, control_state}, 8'h00);
      lift();
      chk("rrise_st", {5'd0, control_state}, 8'h00);
      drop();
      chk("rfall_st", {5'd0, control_state}, 8'h01);
      chk("rfall_ack", acknowledge_interrupt, 8'h02);
      lift();
      drop();
      lift();
      chk("rdone_st", {5'd0, control_state}, 8'h00);
      tick();

`ifdef ACK_SEQ_8080_MODE_EN
      // 8080 three-pulse sequence
      mode_8086       = 1'b0;
      adi             = 1'b0;
      addr_low        = 3'b101;
      addr_high       = 8'h3C;
      highest_request = 8'h20;
      drop();
      chk("c1_dat", data_out, 8'hCD);
      chk("c1_en", {7'd0, data_out_en}, 8'h01);
      mode_8086 = 1'b1;
      lift();
      drop();
      chk("c2_dat", data_out, 8'hB4);
      lift();
      chk("c2r_st", {5'd0, control_state}, 8'h02);
      drop();
      chk("c3_st", {5'd0, control_state}, 8'h03);
      chk("c3_dat", data_out, 8'h3C);
      lift();
      chk("c_end", {5'd0, control_state}, 8'h00);
      chk("c_eoa", {7'd0, end_of_ack}, 8'h01);
      tick();

      // interval 8
      mode_8086 = 1'b0;
      adi       = 1'b1;
      drop();
      lift();
      drop();
      chk("adi_dat", data_out, 8'hA8);
      lift();
      drop();
      lift();
      tick();

      // cascade master
      adi                    = 1'b0;
      cascade_slave          = 1'b0;
      cascade_output_ack_2_3 = 1'b0;
      drop();
      chk("m1_dat", data_out, 8'hCD);
      lift();
      drop();
      chk("m2_en", {7'd0, data_out_en}, 8'h00);
      chk("m2_dat", data_out, 8'h00);
      lift();
      drop();
      chk("m3_en", {7'd0, data_out_en}, 8'h00);
      lift();
      tick();

      // cascade slave
      cascade_slave          = 1'b1;
      cascade_output_ack_2_3 = 1'b1;
      drop();
      chk("s1_en", {7'd0, data_out_en}, 8'h00);
      lift();
      drop();
      chk("s2_dat", data_out, 8'hB4);
      lift();
      drop();
      chk("s3_dat", data_out, 8'h3C);
      lift();
      chk("s_end", {5'd0, control_state}, 8'h00);
      tick();
`else
      // 8080 disabled: mode_8086=0 still gives two pulses
      mode_8086       = 1'b0;
      cascade_slave   = 1'b0;
      addr_low        = 3'b101;
      addr_high       = 8'h3C;
      highest_request = 8'h04;
      drop();
      chk("d1_en", {7'd0, data_out_en}, 8'h00);
      lift();
      drop();
      chk("d2_dat", data_out, 8'h8A);
      lift();
      chk("d_end", {5'd0, control_state}, 8'h00);
      chk("d_eoa", {7'd0, end_of_ack}, 8'h01);
      drop();
      lift();
      drop();
      lift();
      chk("d_noack3", {7'd0, saw_ack3}, 8'h00);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
